cpu_ctrl_fsm: RTL and testbench

//  Parametrised main control sequencer for the SimpleCPU core.
//  - Eight-phase fetch/decode/execute sequence; each phase decodes the IR opcode into datapath strobes.
//  - New over the fixed 3-bit controller: wider opcode field with illegal-opcode trap,

---
 rtl/cpu_ctrl_fsm_pkg.sv | 125 ++++++++++++
 rtl/cpu_ctrl_fsm_wait_timer.sv | 40 ++++
 rtl/cpu_ctrl_fsm.sv | 125 ++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared definitions for the SimpleCPU control sequencer.
//   - opcode values HLT..JMP (low three bits of the IR opcode field)
//   - phase/state encodings PH0..PH7 = 0..7, HALTED = 8
//   - strobe-vector bit positions
//   - phase decode and next-phase helper functions
package cpu_ctrl_fsm_pkg;

   localparam logic [2:0] OpHlt = 3'd0;
   localparam logic [2:0] OpSkz = 3'd1;
   localparam logic [2:0] OpAdd = 3'd2;
   localparam logic [2:0] OpAnd = 3'd3;
   localparam logic [2:0] OpXor = 3'd4;
   localparam logic [2:0] OpLda = 3'd5;
   localparam logic [2:0] OpSto = 3'd6;
   localparam logic [2:0] OpJmp = 3'd7;

   typedef enum logic [3:0] {
      StPh0    = 4'd0,
      StPh1    = 4'd1,
      StPh2    = 4'd2,
      StPh3    = 4'd3,
      StPh4    = 4'd4,
      StPh5    = 4'd5,
      StPh6    = 4'd6,
      StPh7    = 4'd7,
      StHalted = 4'd8
   } state_e;

   // Strobe vector layout {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt}
   localparam int unsigned SbIncPc   = 7;
   localparam int unsigned SbLoadAcc = 6;
   localparam int unsigned SbLoadPc  = 5;
   localparam int unsigned SbRd      = 4;
   localparam int unsigned SbWr      = 3;
   localparam int unsigned SbLoadIr  = 2;
   localparam int unsigned SbDatactl = 1;
   localparam int unsigned SbHalt    = 0;

   // Strobes with side effects that must fire only once across wait-state repeats.
   localparam logic [7:0] OnceMask = 8'b1110_0000;
   localparam logic [7:0] HaltOnly = 8'b0000_0001;

   // Strobes for one phase. An illegal opcode (legal = 0) decodes as a NOP in PH4..PH7.
   function automatic logic [7:0] decode(state_e st, logic [2:0] op, logic legal, logic zero);
      logic [7:0] s;
      logic       is_alu;
      logic       is_skz;
      logic       is_sto;
      logic       is_jmp;
      s      = '0;
      is_alu = legal && ((op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda));
      is_skz = legal && (op == OpSkz);
      is_sto = legal && (op == OpSto);
      is_jmp = legal && (op == OpJmp);
      unique case (st)
         StPh0: begin
            s[SbRd]     = 1'b1;
            s[SbLoadIr] = 1'b1;
         end
         StPh1: begin
            s[SbIncPc]  = 1'b1;
            s[SbRd]     = 1'b1;
            s[SbLoadIr] = 1'b1;
         end
         StPh2: s = '0;
         StPh3: begin
            s[SbIncPc] = 1'b1;
            s[SbHalt]  = legal && (op == OpHlt);
         end
         StPh4: begin
            if (is_jmp) begin
               s[SbIncPc] = 1'b1;
            end else if (is_alu) begin
               s[SbIncPc] = 1'b1;
               s[SbRd]    = 1'b1;
            end else if (is_sto) begin
               s[SbDatactl] = 1'b1;
            end
         end
         StPh5: begin
            if (is_alu) begin
               s[SbLoadAcc] = 1'b1;
               s[SbRd]      = 1'b1;
            end else if (is_skz && zero) begin
               s[SbIncPc] = 1'b1;
            end else if (is_jmp) begin
               s[SbIncPc]  = 1'b1;
               s[SbLoadPc] = 1'b1;
            end else if (is_sto) begin
               s[SbWr]      = 1'b1;
               s[SbDatactl] = 1'b1;
            end
         end
         StPh6: begin
            if (is_sto) begin
               s[SbDatactl] = 1'b1;
            end else if (is_alu) begin
               s[SbRd] = 1'b1;
            end
         end
         StPh7: s[SbIncPc] = is_skz && zero;
         StHalted: s[SbHalt] = 1'b1;
         default: s = '0;
      endcase
      return s;
   endfunction

   function automatic state_e next_phase(state_e st, logic [2:0] op, logic legal);
      state_e ns;
      unique case (st)
         StPh0:    ns = StPh1;
         StPh1:    ns = StPh2;
         StPh2:    ns = StPh3;
         StPh3:    ns = (legal && (op == OpHlt)) ? StHalted : StPh4;
         StPh4:    ns = StPh5;
         StPh5:    ns = StPh6;
         StPh6:    ns = StPh7;
         StPh7:    ns = StPh0;
         StHalted: ns = StHalted;
         default:  ns = StPh0;
      endcase
      return ns;
   endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_wait_timer.sv
// Memory wait-state counter for the control sequencer.
//   clk      falling-edge clock (matches the FSM)
//   rst_n    asynchronous active-low reset
//   clr      clear the count (phase left, or soft reset)
//   hold     one more wait cycle is being spent in the current phase
//   expired  count has reached MAX_WAIT
module ctrl_wait_timer #(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned WCW      = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic hold,
   output logic expired
);

   logic [WCW-1:0] cnt_q;
   logic [WCW-1:0] cnt_d;

   assign expired = (cnt_q == WCW'(MAX_WAIT));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (hold && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// SimpleCPU main control sequencer: eight-phase fetch/decode/execute with illegal-opcode
// trap, memory wait states with timeout, sticky HALTED state with resume.
// State and all outputs update on the falling edge of clk.
//   clk, rst_n              clock (falling edge active), async active-low reset
//   ena                     synchronous run enable, low = soft reset
//   opcode, zero            IR opcode field, accumulator-zero flag
//   mem_rdy, resume         memory ready, leave HALTED
//   inc_pc .. halt          registered datapath strobes
//   illegal_op, bus_err     sticky status flags
//   instr_done              one-cycle pulse after PH7
//   state_o                 current state encoding
module cpu_ctrl_fsm
   import cpu_ctrl_fsm_pkg::*;
#(
   parameter int unsigned OPW      = 3,
   parameter int unsigned MEM_WAIT = 1,
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned WCW      = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ena,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   input  logic           mem_rdy,
   input  logic           resume,
   output logic           inc_pc,
   output logic           load_acc,
   output logic           load_pc,
   output logic           rd,
   output logic           wr,
   output logic           load_ir,
   output logic           datactl_ena,
   output logic           halt,
   output logic           illegal_op,
   output logic           bus_err,
   output logic           instr_done,
   output logic [3:0]     state_o
);

   state_e     state_q;
   logic [7:0] strb_q;
   logic       instr_done_q;
   logic       illegal_q;
   logic       bus_err_q;

   logic       legal;
   logic [2:0] op3;
   logic [7:0] dec;
   logic       wait_req;
   logic       expired;

   // Any opcode bit above [2] marks the code illegal.
   assign legal = ((opcode >> 3) == '0);
   assign op3   = opcode[2:0];
   assign dec   = decode(state_q, op3, legal, zero);

   // The strobes currently driven belong to the phase being left; hold it while memory stalls.
   assign wait_req = (MEM_WAIT != 0) && (strb_q[SbRd] || strb_q[SbWr]) && !mem_rdy;

   ctrl_wait_timer #(
      .MAX_WAIT (MAX_WAIT),
      .WCW      (WCW)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!ena || !wait_req),
      .hold    (wait_req),
      .expired (expired)
   );

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StPh0;
         strb_q       <= '0;
         instr_done_q <= 1'b0;
         illegal_q    <= 1'b0;
         bus_err_q    <= 1'b0;
      end else if (!ena) begin
         state_q      <= StPh0;
         strb_q       <= '0;
         instr_done_q <= 1'b0;
         illegal_q    <= 1'b0;
         bus_err_q    <= 1'b0;
      end else if (state_q == StHalted) begin
         instr_done_q <= 1'b0;
         if (resume) begin
            state_q <= StPh0;
            strb_q  <= '0;
         end else begin
            strb_q <= HaltOnly;
         end
      end else if (wait_req) begin
         instr_done_q <= 1'b0;
         if (expired) begin
            bus_err_q <= 1'b1;
            state_q   <= StHalted;
            strb_q    <= HaltOnly;
         end else begin
            strb_q <= strb_q & ~OnceMask;
         end
      end else begin
         strb_q       <= dec;
         instr_done_q <= (state_q == StPh7);
         if ((state_q == StPh3) && !legal) begin
            illegal_q <= 1'b1;
         end
         state_q <= next_phase(state_q, op3, legal);
      end
   end

   assign inc_pc      = strb_q[SbIncPc];
   assign load_acc    = strb_q[SbLoadAcc];
   assign load_pc     = strb_q[SbLoadPc];
   assign rd          = strb_q[SbRd];
   assign wr          = strb_q[SbWr];
   assign load_ir     = strb_q[SbLoadIr];
   assign datactl_ena = strb_q[SbDatactl];
   assign halt        = strb_q[SbHalt];
   assign illegal_op  = illegal_q;
   assign bus_err     = bus_err_q;
   assign instr_done  = instr_done_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm (OPW=5, MEM_WAIT=1, MAX_WAIT=15, WCW=4).
// The DUT acts on the falling edge; the bench drives and samples around the rising edge.
module tb_cpu_ctrl_fsm;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [4:0] opcode;
   logic       zero;
   logic       mem_rdy;
   logic       resume;
   logic       inc_pc;
   logic       load_acc;
   logic       load_pc;
   logic       rd;
   logic       wr;
   logic       load_ir;
   logic       datactl_ena;
   logic       halt;
   logic       illegal_op;
   logic       bus_err;
   logic       instr_done;
   logic [3:0] state_o;

   logic [7:0] strb;
   assign strb = {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt};

   cpu_ctrl_fsm #(
      .OPW      (5),
      .MEM_WAIT (1),
      .MAX_WAIT (15),
      .WCW      (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .opcode      (opcode),
      .zero        (zero),
      .mem_rdy     (mem_rdy),
      .resume      (resume),
      .inc_pc      (inc_pc),
      .load_acc    (load_acc),
      .load_pc     (load_pc),
      .rd          (rd),
      .wr          (wr),
      .load_ir     (load_ir),
      .datactl_ena (datactl_ena),
      .halt        (halt),
      .illegal_op  (illegal_op),
      .bus_err     (bus_err),
      .instr_done  (instr_done),
      .state_o     (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] op;
      logic       z;
      logic [7:0] exp_strb;
      logic [3:0] exp_st;
      logic       exp_done;
   } vec_t;

   vec_t vecs[40];
   int   nv;
   int   n_checks;
   int   n_pass;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // One active (falling) edge, then return at the following rising edge for sampling.
   task automatic tick();
      @(negedge clk);
      @(posedge clk);
   endtask

   task automatic add(input logic [4:0] op, input logic z, input logic [7:0] s,
                      input logic [3:0] st, input logic d);
      vecs[nv].op       = op;
      vecs[nv].z        = z;
      vecs[nv].exp_strb = s;
      vecs[nv].exp_st   = st;
      vecs[nv].exp_done = d;
      nv++;
   endtask

   task automatic add_instr(input logic [4:0] op, input logic z, input logic [7:0] s4,
                            input logic [7:0] s5, input logic [7:0] s6, input logic [7:0] s7);
      add(op, z, 8'h14, 4'd1, 1'b0);
      add(op, z, 8'h94, 4'd2, 1'b0);
      add(op, z, 8'h00, 4'd3, 1'b0);
      add(op, z, 8'h80, 4'd4, 1'b0);
      add(op, z, s4,    4'd5, 1'b0);
      add(op, z, s5,    4'd6, 1'b0);
      add(op, z, s6,    4'd7, 1'b0);
      add(op, z, s7,    4'd0, 1'b1);
   endtask

   initial begin
      int edges;
      int incs;
      n_checks = 0;
      n_pass   = 0;
      nv       = 0;
      rst_n    = 1'b0;
      ena      = 1'b0;
      opcode   = '0;
      zero     = 1'b0;
      mem_rdy  = 1'b1;
      resume   = 1'b0;

      // Strobe vectors {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt}
      add_instr(5'd5, 1'b0, 8'h90, 8'h50, 8'h10, 8'h00);  // LDA
      add_instr(5'd1, 1'b1, 8'h00, 8'h80, 8'h00, 8'h80);  // SKZ, zero=1
      add_instr(5'd1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);  // SKZ, zero=0
      add_instr(5'd7, 1'b0, 8'h80, 8'hA0, 8'h00, 8'h00);  // JMP
      add_instr(5'd6, 1'b0, 8'h02, 8'h0A, 8'h02, 8'h00);  // STO

      // Reset state
      @(posedge clk);
      check("reset strobes", 32'(strb), 32'h00);
      check("reset state", 32'(state_o), 32'd0);
      check("reset status", 32'({illegal_op, bus_err, instr_done}), 32'd0);
      rst_n = 1'b1;
      ena   = 1'b1;

      // Table: LDA, SKZ (both zero values), JMP, STO at full memory speed
      for (int i = 0; i < nv; i++) begin
         opcode = vecs[i].op;
         zero   = vecs[i].z;
         tick();
         check($sformatf("vec%0d strobes", i), 32'(strb), 32'(vecs[i].exp_strb));
         check($sformatf("vec%0d state", i), 32'(state_o), 32'(vecs[i].exp_st));
         check($sformatf("vec%0d done", i), 32'(instr_done), 32'(vecs[i].exp_done));
      end
      check("table status", 32'({illegal_op, bus_err}), 32'd0);

      // STO with three wait cycles in PH5: 11 cycles total
      opcode = 5'd6;
      zero   = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("sto ph5 strobes", 32'(strb), 32'h0A);
      mem_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("sto wait%0d strobes", i), 32'(strb), 32'h0A);
         check($sformatf("sto wait%0d state", i), 32'(state_o), 32'd6);
      end
      mem_rdy = 1'b1;
      tick();
      check("sto ph6 strobes", 32'(strb), 32'h02);
      check("sto ph6 state", 32'(state_o), 32'd7);
      tick();
      check("sto end done", 32'(instr_done), 32'd1);
      check("sto end state", 32'(state_o), 32'd0);

      // ADD with mem_rdy stuck low after PH4: timeout, bus_err, halt
      opcode = 5'd2;
      for (int i = 0; i < 5; i++) tick();
      check("add ph4 strobes", 32'(strb), 32'h90);
      incs    = 1;
      edges   = 0;
      mem_rdy = 1'b0;
      while (edges < 40 && !halt) begin
         tick();
         edges++;
         if (inc_pc) incs++;
      end
      check("timeout edges", 32'(edges), 32'd16);
      check("timeout inc_pc pulses", 32'(incs), 32'd1);
      check("timeout bus_err", 32'(bus_err), 32'd1);
      check("timeout strobes", 32'(strb), 32'h01);
      check("timeout state", 32'(state_o), 32'd8);
      mem_rdy = 1'b1;
      tick();
      check("halted hold strobes", 32'(strb), 32'h01);
      check("halted hold bus_err", 32'(bus_err), 32'd1);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      check("resume state", 32'(state_o), 32'd0);
      check("resume halt", 32'(halt), 32'd0);
      check("resume bus_err sticky", 32'(bus_err), 32'd1);
      ena = 1'b0;
      tick();
      check("ena low strobes", 32'(strb), 32'h00);
      check("ena low bus_err", 32'(bus_err), 32'd0);
      check("ena low state", 32'(state_o), 32'd0);
      ena = 1'b1;

      // HLT: halted after 4 cycles, held until resume
      opcode = 5'd0;
      tick();
      check("hlt ph0", 32'(strb), 32'h14);
      tick();
      tick();
      check("hlt ph2 state", 32'(state_o), 32'd3);
      tick();
      check("hlt ph3 strobes", 32'(strb), 32'h81);
      check("hlt ph3 state", 32'(state_o), 32'd8);
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("halted%0d strobes", i), 32'(strb), 32'h01);
         check($sformatf("halted%0d state", i), 32'(state_o), 32'd8);
      end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      check("hlt resume strobes", 32'(strb), 32'h00);
      check("hlt resume state", 32'(state_o), 32'd0);

      // Illegal opcode: NOP execution, then async reset mid-PH5
      opcode = 5'b01010;
      for (int i = 0; i < 4; i++) tick();
      check("illegal ph3 strobes", 32'(strb), 32'h80);
      check("illegal ph3 state", 32'(state_o), 32'd4);
      check("illegal flag", 32'(illegal_op), 32'd1);
      tick();
      check("illegal ph4 strobes", 32'(strb), 32'h00);
      check("illegal ph4 state", 32'(state_o), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst strobes", 32'(strb), 32'h00);
      check("async rst state", 32'(state_o), 32'd0);
      check("async rst status", 32'({illegal_op, bus_err, instr_done}), 32'd0);
      @(posedge clk);
      rst_n  = 1'b1;
      opcode = 5'd5;
      tick();
      check("post rst strobes", 32'(strb), 32'h14);
      check("post rst state", 32'(state_o), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
